// File: rtl/main_memory_ctrl_if.sv
// Cache-to-backing-store request bus: the cache is the master, main_memory_ctrl the slave.
// Handshake: mem_req is held by the master until mem_ready pulses for one cycle; mem_busy spans acceptance to that pulse.
interface main_memory_ctrl_if;
    logic        mem_req;
    logic        mem_rw;
    logic [9:0]  mem_addr;
    logic [19:0] mem_wdata;
    logic [19:0] mem_rdata;
    logic        mem_ready;
    logic        mem_busy;

    modport master (
        output mem_req,
        output mem_rw,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready,
        input  mem_busy
    );

    modport slave (
        input  mem_req,
        input  mem_rw,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready,
        output mem_busy
    );
endinterface

// File: rtl/main_memory_ctrl.sv
// 512 x 20-bit backing store answering one line read or write per request after LATENCY cycles.
// LATENCY must lie in 1..15 (4-bit countdown).
module main_memory_ctrl #(
    parameter int unsigned LATENCY = 3
) (
    input  logic               clk,
    input  logic               rst,
    main_memory_ctrl_if.slave  bus,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  line_q, line_d;
    logic        rw_q, rw_d;
    logic [19:0] wdata_q, wdata_d;
    logic [19:0] rdata_q, rdata_d;
    logic        enter_done;
    logic        unused_addr0;

    // The array stores each line XOR its own word-address pattern, so an all-zero
    // power-up image reads back as "every word holds its own address".
    logic [19:0] delta_q [512] = '{default: '0};

    function automatic logic [19:0] home_pattern(input logic [8:0] line);
        return {line, 1'b1, line, 1'b0};
    endfunction

    assign unused_addr0 = bus.mem_addr[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            line_q  <= 9'd0;
            rw_q    <= 1'b0;
            wdata_q <= 20'd0;
            rdata_q <= 20'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    line_d  = bus.mem_addr[9:1];
                    rw_d    = bus.mem_rw;
                    wdata_d = bus.mem_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands come from the _d side so the LATENCY=1 path (IDLE->DONE) sees the freshly latched request.
    assign enter_done = (state_d == DONE) && (state_q != DONE);

    always_comb begin
        rdata_d = rdata_q;
        if (enter_done && !rw_d) begin
            rdata_d = delta_q[line_d] ^ home_pattern(line_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && enter_done && rw_d) begin
            delta_q[line_d] <= wdata_d ^ home_pattern(line_d);
        end
    end

    always_comb begin
        bus.mem_ready = (state_q == DONE);
        bus.mem_busy  = (state_q != IDLE);
        bus.mem_rdata = rdata_q;
        dbg_state_o   = state_q;
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl: a LATENCY=3 instance for most scenarios and a LATENCY=1 instance.
module tb_main_memory_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    main_memory_ctrl_if a_if ();
    main_memory_ctrl_if b_if ();
    logic [1:0] a_state;
    logic [1:0] b_state;

    main_memory_ctrl #(.LATENCY(3)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .bus         (a_if),
        .dbg_state_o (a_state)
    );

    main_memory_ctrl #(.LATENCY(1)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .bus         (b_if),
        .dbg_state_o (b_state)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [19:0] exp_q [$];
    logic [19:0] last_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction on the LATENCY=3 instance. rst_at>0 asserts reset at that
    // sample after acceptance; disturb scrambles the request inputs while busy.
    task automatic txn_a(input logic rw, input logic [9:0] addr, input logic [19:0] wd,
                         input int rst_at, input bit disturb);
        int          n;
        bit          seen;
        logic [19:0] exp;
        @(negedge clk);
        a_if.mem_req   = 1'b1;
        a_if.mem_rw    = rw;
        a_if.mem_addr  = addr;
        a_if.mem_wdata = wd;
        @(posedge clk);
        #1;
        a_if.mem_req = 1'b0;
        if (disturb) begin
            a_if.mem_addr  = 10'd0;
            a_if.mem_rw    = 1'b1;
            a_if.mem_wdata = 20'hFFFFF;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) check_eq("busy_rise", a_if.mem_busy, 1);
            if (n == rst_at) begin
                rst = 1'b0;
                #1;
                check_eq("rst_ready", a_if.mem_ready, 0);
                check_eq("rst_busy", a_if.mem_busy, 0);
                check_eq("rst_rdata", a_if.mem_rdata, 0);
                check_eq("rst_state", a_state, 0);
                last_rd = 20'd0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (a_if.mem_ready) seen = 1'b1;
        end
        check_eq("ready_latency", n, 3);
        check_eq("busy_at_ready", a_if.mem_busy, 1);
        if (!rw) begin
            exp = exp_q.pop_front();
            check_eq("rdata", a_if.mem_rdata, exp);
            last_rd = exp;
        end else begin
            check_eq("wr_rdata_hold", a_if.mem_rdata, last_rd);
        end
        @(negedge clk);
        check_eq("ready_single", a_if.mem_ready, 0);
        check_eq("busy_fall", a_if.mem_busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int pulses;
        int first_i;
        int last_i;
        int idle_cnt;
        logic [19:0] exp;

        rst = 1'b0;
        a_if.mem_req = 1'b0; a_if.mem_rw = 1'b0; a_if.mem_addr = 10'd0; a_if.mem_wdata = 20'd0;
        b_if.mem_req = 1'b0; b_if.mem_rw = 1'b0; b_if.mem_addr = 10'd0; b_if.mem_wdata = 20'd0;
        last_rd = 20'd0;
        repeat (2) @(negedge clk);
        check_eq("reset_ready", a_if.mem_ready, 0);
        check_eq("reset_busy", a_if.mem_busy, 0);
        check_eq("reset_rdata", a_if.mem_rdata, 0);
        check_eq("reset_state", a_state, 0);
        check_eq("b_reset_busy", b_if.mem_busy, 0);
        rst = 1'b1;

        // Read after reset
        exp_q.push_back({10'd51, 10'd50});
        txn_a(1'b0, 10'd50, 20'd0, 0, 1'b0);

        // Write then read the same line through the odd word address
        txn_a(1'b1, 10'd84, {10'd400, 10'd300}, 0, 1'b0);
        exp_q.push_back({10'd400, 10'd300});
        txn_a(1'b0, 10'd85, 20'd0, 0, 1'b0);

        // Held request: 12 cycles -> three pulses, four cycles apart
        @(negedge clk);
        a_if.mem_req  = 1'b1;
        a_if.mem_rw   = 1'b0;
        a_if.mem_addr = 10'd2;
        pulses = 0; first_i = 0; last_i = 0; idle_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (a_if.mem_ready) begin
                pulses++;
                if (pulses == 1) first_i = i;
                last_i = i;
                check_eq("held_rdata", a_if.mem_rdata, {10'd3, 10'd2});
            end
            if (!a_if.mem_busy && i <= 11) idle_cnt++;
            if (i == 12) a_if.mem_req = 1'b0;
        end
        check_eq("held_pulses", pulses, 3);
        check_eq("held_first", first_i, 3);
        check_eq("held_span", last_i - first_i, 8);
        check_eq("held_idle_gaps", idle_cnt, 2);
        @(negedge clk);
        check_eq("held_stop", a_if.mem_busy, 0);
        last_rd = {10'd3, 10'd2};

        // Operand latching: inputs change to a write of address 0 while busy
        exp_q.push_back({10'd71, 10'd70});
        txn_a(1'b0, 10'd70, 20'd0, 0, 1'b1);
        exp_q.push_back({10'd1, 10'd0});
        txn_a(1'b0, 10'd0, 20'd0, 0, 1'b0);

        // Reset one cycle into a write: nothing committed
        txn_a(1'b1, 10'd20, 20'hFFFFF, 1, 1'b0);
        exp_q.push_back({10'd21, 10'd20});
        txn_a(1'b0, 10'd20, 20'd0, 0, 1'b0);

        // Reset during the DONE cycle of a write: write stays
        txn_a(1'b1, 10'd30, {10'd5, 10'd6}, 3, 1'b0);
        exp_q.push_back({10'd5, 10'd6});
        txn_a(1'b0, 10'd31, 20'd0, 0, 1'b0);

        // LATENCY=1 instance
        @(negedge clk);
        b_if.mem_req  = 1'b1;
        b_if.mem_rw   = 1'b0;
        b_if.mem_addr = 10'd1022;
        @(posedge clk);
        #1;
        b_if.mem_req = 1'b0;
        @(negedge clk);
        exp = {10'd1023, 10'd1022};
        check_eq("b_ready", b_if.mem_ready, 1);
        check_eq("b_busy", b_if.mem_busy, 1);
        check_eq("b_rdata", b_if.mem_rdata, exp);
        @(negedge clk);
        check_eq("b_ready_single", b_if.mem_ready, 0);
        check_eq("b_busy_fall", b_if.mem_busy, 0);
        check_eq("b_rdata_hold", b_if.mem_rdata, exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/main_memory_ctrl.md
# main_memory_ctrl

Backing-store controller that sits directly downstream of the direct-mapped cache and serves its line fills and write-backs. It holds 512 lines of 20 bits (two 10-bit words per line) and answers each accepted request after a fixed, parameterised latency. It signals completion with a one-cycle `mem_ready` pulse. Read data is returned on a dedicated output bus; the cache-side tri-state is handled outside this block.

## Interface
- `LATENCY`, default 3: cycles from request acceptance to the `mem_ready` pulse. Legal range is 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_req`  in  1  request valid; sampled only in IDLE.
- `mem_rw`  in  1  0 = line read, 1 = line write.
- `mem_addr`  in  10  word address; line index = `mem_addr[9:1]`, and `mem_addr[0]` is ignored.
- `mem_wdata`  in  20  write line: `[9:0]` = even word, `[19:10]` = odd word.
- `mem_rdata`  out  20  read line, same packing as `mem_wdata`.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_busy`  out  1  high from acceptance through the `mem_ready` cycle.

## Operation
- Storage: 512 × 20-bit array.
  - Simulation initial content: line L has `[9:0]` = 2L and `[19:10]` = 2L+1, so each word holds its own word address.
  - Reset does not alter the array.
- The FSM has three states, IDLE, WAIT and DONE:
  - **IDLE**: if `mem_req`=1, latch `mem_addr[9:1]`, `mem_rw` and `mem_wdata`, load the counter with `LATENCY`-1, and go to WAIT (or DONE directly when `LATENCY`=1). Otherwise stay in IDLE.
  - **WAIT**: decrement the counter each cycle. When the counter is 1, go to DONE.
  - **DONE**: `mem_ready`=1 for exactly this cycle, then unconditionally return to IDLE. `mem_req` is ignored in DONE.
- **Read**: on the edge entering DONE, `mem_rdata` is loaded with the latched line's contents. It holds that value until the next read completes.
- **Write**: the latched `mem_wdata` is committed to the array on the edge entering DONE, and `mem_rdata` is unchanged.
- While busy, `mem_req`, `mem_addr`, `mem_rw` and `mem_wdata` are don't-care. All operands come from the latches taken at acceptance.
- There is no request queueing. A request seen outside IDLE is dropped; the requester must hold `mem_req` until it sees `mem_ready`.
- A read of a line in the same request stream immediately after a write to it returns the newly written data, because the write is committed before the next acceptance is possible.

## Timing
- Reset values: state = IDLE, counter = 0, `mem_ready`=0, `mem_busy`=0, `mem_rdata`=20'd0, latches = 0.
- Acceptance at edge T (state IDLE, `mem_req`=1):
  - `mem_busy` rises after T.
  - `mem_ready` is high in the cycle after edge T+`LATENCY`-1, i.e. exactly `LATENCY` cycles after the acceptance edge.
  - With `LATENCY`=1, `mem_ready` is high in the cycle immediately after acceptance.
- `mem_rdata` is valid in the `mem_ready` cycle and afterwards.
- `mem_busy` falls together with `mem_ready`.
- Throughput: at most one request per `LATENCY`+1 cycles, because DONE always returns to IDLE for at least one cycle.
- `mem_req` held continuously produces back-to-back transactions spaced `LATENCY`+1 cycles apart.
- Reset asserted mid-transaction:
  - Immediately abort to IDLE and drive `mem_ready`=0, `mem_busy`=0, `mem_rdata`=0.
  - A write whose DONE edge has not occurred is not committed.
  - Reset asserted during the DONE cycle leaves the already-committed write in place.
- Reset deasserted: the first acceptance can occur on the first rising edge with `rst`=1.

## Test plan
- **Read after reset** (`LATENCY`=3): req read `mem_addr`=50. Required: `mem_ready` pulses exactly 3 cycles after acceptance, and `mem_rdata` = {10'd51, 10'd50}.
- **Write then read**: write `mem_addr`=84 with `mem_wdata`={10'd400, 10'd300}, then read `mem_addr`=85. Required: the second transaction returns {10'd400, 10'd300}, and `mem_ready` pulses once per transaction.
- **Held request**: `mem_req` held high for 12 cycles with `LATENCY`=3. Required: exactly 3 `mem_ready` pulses at 4-cycle spacing, and `mem_busy` low for one cycle between them.
- **Operand latching**: accept a read at address 70, then change `mem_addr` to 0 and `mem_rw` to 1 during WAIT. Required: `mem_rdata` = {10'd71, 10'd70}, and no write occurs.
- **Reset mid-write**: accept a write of 20'hFFFFF to line 10 and pulse `rst` low one cycle after acceptance. Required: outputs go to 0 immediately, and a subsequent read of address 20 returns {10'd21, 10'd20}.
- **`LATENCY`=1 build**: read `mem_addr`=1022. Required: `mem_ready` is high in the cycle right after acceptance, and `mem_rdata` = {10'd1023, 10'd1022}.
